regfile_write_arbiter: RTL

- Shares the register file's single write port among three requesters:
  - 0: ALU writeback
  - 1: load unit
  - 2: stack-pointer update
- Arbitrates round-robin and grants at most one requester per cycle with a combinational ack.
- Drives a registered write command (enable, address, data) into the register file. The register file commits it on the following falling edge.
- Sits between the execute/memory stages and the register file.

---
 rtl/regfile_write_arbiter.sv | 89 ++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Purpose: shares the register file write port among ALU (0), load unit (1) and SP update (2).
// Latency: ack is combinational in the request cycle; the write command is registered one posedge later.
// Backpressure: requesters hold req/addr/data until ack; hold or reset blocks every grant, and busy flags a stalled request.
// Build option REGARB_FIXED_PRIO_EN selects fixed priority 0 > 1 > 2 instead of round-robin.
module regfile_write_arbiter #(
  parameter int         NREQ     = 3,
  parameter logic [3:0] ZERO_REG = 4'hF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [4*NREQ-1:0]    req_addr,
  input  logic [16*NREQ-1:0]   req_data,
  input  logic                 hold,
  output logic [NREQ-1:0]      ack,
  output logic                 reg_write,
  output logic [3:0]           write_reg,
  output logic [15:0]          write_data,
  output logic                 busy
);

  logic [1:0]      rr_ptr;
  logic [NREQ-1:0] gnt;
  logic [3:0]      sel_addr;
  logic [15:0]     sel_data;
  int              idx;

`ifdef REGARB_FIXED_PRIO_EN
  // Fixed priority: the search always starts at requester 0.
  assign rr_ptr = 2'd0;
`else
  logic [1:0] nxt_ptr;
`endif

  // Search from rr_ptr upward (mod NREQ); the first pending request wins.
  always_comb begin
    gnt      = '0;
    sel_addr = '0;
    sel_data = '0;
    idx      = 0;
`ifndef REGARB_FIXED_PRIO_EN
    nxt_ptr  = rr_ptr;
`endif
    if (reset && !hold) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (gnt == '0 && req[idx]) begin
          gnt[idx] = 1'b1;
          sel_addr = req_addr[4*idx +: 4];
          sel_data = req_data[16*idx +: 16];
`ifndef REGARB_FIXED_PRIO_EN
          nxt_ptr  = (idx == NREQ-1) ? 2'd0 : 2'(idx + 1);
`endif
        end
      end
    end
  end

  assign ack  = gnt;
  assign busy = (|req) & ~(|ack);

`ifndef REGARB_FIXED_PRIO_EN
  // Move priority to the requester just after the one granted; hold otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= 2'd0;
    end else if (|gnt) begin
      rr_ptr <= nxt_ptr;
    end
  end
`endif

  // Register the granted write; writes to the zero register load but do not enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write  <= 1'b0;
      write_reg  <= 4'd0;
      write_data <= 16'd0;
    end else if (|gnt) begin
      reg_write  <= (sel_addr != ZERO_REG);
      write_reg  <= sel_addr;
      write_data <= sel_data;
    end else begin
      reg_write  <= 1'b0;
    end
  end

endmodule
